// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: 2-entry skid-buffered elastic stage with flush/stall; define PIPE_STAGE_PERF_EN for bubble/backpressure counters
module pipe_stage_elastic #(
  parameter int DATA_W   = 128,
  parameter bit RST_ZERO = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_bubble_o,
  output logic [CNT_W-1:0]  perf_bp_o
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_head, r_skid, w_head_nxt, w_skid_nxt;
  logic w_head_v, w_skid_v, w_acc, w_dlv;
  assign w_head_v    = r_state[1];
  assign w_skid_v    = r_state[0];
  assign in_ready_o  = !w_skid_v && !stall_i;
  assign out_valid_o = w_head_v && !stall_i;
  assign out_data_o  = r_head;
  assign occupancy_o = {1'b0, w_head_v} + {1'b0, w_skid_v};
  assign w_acc       = in_valid_i && in_ready_o;
  assign w_dlv       = out_valid_o && out_ready_i;
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      EMPTY: begin
        w_head_nxt  = w_acc ? in_data_i : r_head;
        w_state_nxt = w_acc ? ONE : EMPTY;
      end
      ONE: begin
        w_head_nxt  = (w_acc && w_dlv) ? in_data_i : r_head;
        w_skid_nxt  = (w_acc && !w_dlv) ? in_data_i : r_skid;
        w_state_nxt = (w_acc && !w_dlv) ? FULL : (!w_acc && w_dlv) ? EMPTY : ONE;
      end
      FULL: begin
        w_head_nxt  = w_dlv ? r_skid : r_head;
        w_state_nxt = w_dlv ? ONE : FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush_i) begin
      w_state_nxt = EMPTY;
      w_head_nxt  = RST_ZERO ? '0 : w_head_nxt;
      w_skid_nxt  = RST_ZERO ? '0 : w_skid_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      if (RST_ZERO) begin
        r_head <= '0;
        r_skid <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_bubble, r_bp;
  assign perf_bubble_o = r_bubble;
  assign perf_bp_o     = r_bp;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble <= '0;
      r_bp     <= '0;
    end else begin
      if (out_ready_i && !w_head_v && !stall_i && !(&r_bubble)) r_bubble <= r_bubble + 1'b1;
      if (w_head_v && !out_ready_i && !stall_i && !(&r_bp)) r_bp <= r_bp + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed plan plus random traffic against a queue model of the elastic stage
module tb_pipe_stage_elastic;
  localparam int DW = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, flush_i, stall_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [1:0] occupancy_o;
  int n_chk = 0;
  int n_bad = 0;
  bit live = 1'b0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] hd = '0;
  always #5 clk = ~clk;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] perf_bubble_o, perf_bp_o;
  int m_bub = 0;
  int m_bp = 0;
`endif
  pipe_stage_elastic #(.DATA_W(DW), .RST_ZERO(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_bubble_o(perf_bubble_o), .perf_bp_o(perf_bp_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit f, input bit s, input bit iv, input logic [DW-1:0] d, input bit ordy);
    bit acc, dlv;
    @(negedge clk);
    rst = r; flush_i = f; stall_i = s; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
    #1;
    if (live) begin
      chk("in_ready", 32'(in_ready_o), 32'(q.size() < 2 && !s));
      chk("out_valid", 32'(out_valid_o), 32'(q.size() > 0 && !s));
      chk("occupancy", 32'(occupancy_o), 32'(q.size()));
      chk("out_data", 32'(out_data_o), 32'(q.size() > 0 ? q[0] : hd));
`ifdef PIPE_STAGE_PERF_EN
      chk("perf_bubble", 32'(perf_bubble_o), 32'(m_bub));
      chk("perf_bp", 32'(perf_bp_o), 32'(m_bp));
`endif
    end
    @(posedge clk);
`ifdef PIPE_STAGE_PERF_EN
    if (r) begin
      m_bub = 0;
      m_bp = 0;
    end else if (!s) begin
      if (ordy && q.size() == 0 && m_bub < 15) m_bub++;
      if (!ordy && q.size() > 0 && m_bp < 15) m_bp++;
    end
`endif
    if (r || f) begin
      q.delete();
      hd = '0;
    end else if (!s) begin
      acc = iv && q.size() < 2;
      dlv = ordy && q.size() > 0;
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (q.size() > 0) hd = q[0];
    end
  endtask
  initial begin
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    live = 1'b1;
    step(0, 0, 0, 0, '0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, DW'(i), 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 1, 16'hA, 0);
    step(0, 0, 0, 1, 16'hB, 0);
    step(0, 0, 0, 1, 16'hC, 0);
    chk("full_occ", 32'(occupancy_o), 32'd2);
    step(0, 0, 0, 1, 16'hC, 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 1, 16'hA, 0);
    step(0, 0, 0, 1, 16'hB, 0);
    step(0, 1, 0, 1, 16'hD, 0);
    step(0, 0, 0, 0, '0, 1);
    chk("flush_data", 32'(out_data_o), 32'd0);
    step(0, 0, 0, 1, 16'h5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h6, 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
`ifdef PIPE_STAGE_PERF_EN
    step(0, 0, 0, 1, 16'h7, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0, 0);
    chk("bp_sat", 32'(perf_bp_o), 32'hF);
    step(0, 1, 0, 0, '0, 0);
    step(0, 0, 1, 0, '0, 0);
    chk("bp_after_flush", 32'(perf_bp_o), 32'hF);
    step(1, 0, 1, 0, '0, 0);
    step(0, 0, 1, 0, '0, 0);
    chk("bp_after_rst", 32'(perf_bp_o), 32'h0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(19) == 0, $urandom_range(5) == 0,
           1'($urandom), DW'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
